sw_cond: RTL and testbench
==========================

SW_COND -- requirements
Module: sw_cond

Interface
REQ-001 SHALL have parameter DEB_CYC, default 500000, stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYC, default 50000000, held cycles after accepted press before long-press event (1 s).
REQ-003 SHALL have parameter RPT_CYC, default 10000000, auto-repeat period after long press (200 ms).
REQ-004 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_sw  input  4  raw push-button inputs, active-low (0 = pressed), asynchronous to clk.
REQ-007 SHALL have port o_level  output  4  debounced pressed level per channel, 1 = pressed.
REQ-008 SHALL have port o_press  output  4  one-cycle pulse when a press is accepted.
REQ-009 SHALL have port o_release  output  4  one-cycle pulse when a release is accepted.
REQ-010 SHALL have port o_long  output  4  one-cycle pulse when a hold reaches LONG_CYC.
REQ-011 SHALL have port o_rpt  output  4  one-cycle auto-repeat pulses during a long hold.

Function
REQ-012 SHALL process the four channels independently and identically; any combination of channels may be active in the same cycle.
REQ-013 SHALL pass each i_sw bit through a 2-flop synchronizer, inverted, giving sampled level s (1 = pressed).
REQ-014 SHALL keep a per-channel debounce counter: clear when s == o_level; increment when s != o_level.
REQ-015 SHALL toggle o_level, and clear the debounce counter, on the edge where the counter would reach DEB_CYC (i.e. DEB_CYC consecutive mismatching samples).
REQ-016 SHALL ignore any glitch on s shorter than DEB_CYC cycles; the counter restarts from 0 on each return to o_level.
REQ-017 SHALL assert o_press for exactly one cycle, coincident with the cycle o_level goes 0->1; o_release likewise for 1->0.
REQ-018 SHALL give a press latency of DEB_CYC+2 clk cycles from the first edge at which the new i_sw value is stable, to o_press high.
REQ-019 SHALL implement a per-channel FSM: IDLE (o_level=0) -> HELD on accepted press -> REPEAT on hold count reaching LONG_CYC; HELD or REPEAT -> IDLE on accepted release.
REQ-020 SHALL in HELD count cycles from the o_press cycle; on the cycle the count equals LONG_CYC, pulse o_long and o_rpt together, clear the count, and enter REPEAT.
REQ-021 SHALL in REPEAT pulse o_rpt once every RPT_CYC cycles, with no further o_long pulses.
REQ-022 SHALL drop to IDLE on accepted release with no o_long/o_rpt in that cycle; a release accepted in the same cycle as a pending long/repeat event suppresses that event.
REQ-023 SHALL use 32-bit counters; the hold counter never wraps because it is cleared at each event.
REQ-024 SHALL require DEB_CYC >= 1, LONG_CYC >= 1, RPT_CYC >= 1; behaviour for 0 is undefined.

Reset
REQ-025 SHALL on rst_n=0 immediately force o_level=0, all pulse outputs=0, every counter=0, every FSM to IDLE, and synchronizer flops to 0 (not pressed).
REQ-026 SHALL treat a button held across reset deassertion as a new press, accepted after DEB_CYC+2 cycles; reset mid-hold aborts all pending long/repeat events.

Verification (bench parameters DEB_CYC=4, LONG_CYC=20, RPT_CYC=5)
REQ-027 SHALL cover: i_sw[0] driven 1->0 and held -> o_press[0] single pulse 6 cycles after the edge, o_level[0]=1 from that cycle.
REQ-028 SHALL cover: i_sw[1] low for 3 cycles then high -> no o_press/o_level change on any channel.
REQ-029 SHALL cover: i_sw[2] held 40 cycles past o_press -> o_long[2]+o_rpt[2] at press+20, o_rpt[2] at +25, +30, +35, +40; one o_release after release+6.
REQ-030 SHALL cover: i_sw[0] and i_sw[3] pressed same cycle -> o_press=4'b1001 in a single cycle.
REQ-031 SHALL cover: rst_n pulsed low at press+10 while held -> outputs 0 at once; after release of reset, o_press again DEB_CYC+2 cycles later, o_long 20 cycles after that.
REQ-032 SHALL cover: release accepted exactly at hold count 20 -> o_release pulse, no o_long/o_rpt.

Source files
------------

// File: rtl/sw_cond.sv
// sw_cond: four-channel push-button conditioner with debounce, press/release, long-press and auto-repeat events
module sw_cond #(
    parameter int unsigned DEB_CYC  = 500000,
    parameter int unsigned LONG_CYC = 50000000,
    parameter int unsigned RPT_CYC  = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_sw,
    output logic [3:0] o_level,
    output logic [3:0] o_press,
    output logic [3:0] o_release,
    output logic [3:0] o_long,
    output logic [3:0] o_rpt
);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  level_q, level_d;
    logic [3:0]  press_q, press_d;
    logic [3:0]  release_q, release_d;
    logic [3:0]  long_q, long_d;
    logic [3:0]  rpt_q, rpt_d;
    logic [31:0] deb_q [4];
    logic [31:0] deb_d [4];
    logic [31:0] hold_q [4];
    logic [31:0] hold_d [4];
    state_t      st_q [4];
    state_t      st_d [4];

    // Debounce each synchronized level, then sequence hold events from the accepted level
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        rpt_d     = '0;
        for (int i = 0; i < 4; i++) begin
            deb_d[i]  = deb_q[i];
            hold_d[i] = hold_q[i];
            st_d[i]   = st_q[i];
            if (sync2_q[i] == level_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] == DEB_CYC - 1) begin
                deb_d[i]     = '0;
                level_d[i]   = ~level_q[i];
                press_d[i]   = ~level_q[i];
                release_d[i] = level_q[i];
            end else begin
                deb_d[i] = deb_q[i] + 32'd1;
            end
            case (st_q[i])
                IDLE: begin
                    if (press_d[i]) begin
                        st_d[i]   = HELD;
                        hold_d[i] = '0;
                    end
                end
                HELD: begin
                    if (release_d[i]) begin
                        st_d[i]   = IDLE;
                        hold_d[i] = '0;
                    end else if (hold_q[i] + 32'd1 == LONG_CYC) begin
                        st_d[i]   = REPEAT;
                        hold_d[i] = '0;
                        long_d[i] = 1'b1;
                        rpt_d[i]  = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + 32'd1;
                    end
                end
                REPEAT: begin
                    if (release_d[i]) begin
                        st_d[i]   = IDLE;
                        hold_d[i] = '0;
                    end else if (hold_q[i] + 32'd1 == RPT_CYC) begin
                        hold_d[i] = '0;
                        rpt_d[i]  = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + 32'd1;
                    end
                end
                default: begin
                    st_d[i]   = IDLE;
                    hold_d[i] = '0;
                end
            endcase
        end
    end

    // Synchronize inverted buttons and register all channel state and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            rpt_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= '0;
                hold_q[i] <= '0;
                st_q[i]   <= IDLE;
            end
        end else begin
            sync1_q   <= ~i_sw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
            for (int i = 0; i < 4; i++) begin
                deb_q[i]  <= deb_d[i];
                hold_q[i] <= hold_d[i];
                st_q[i]   <= st_d[i];
            end
        end
    end

    assign o_level   = level_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;
    assign o_rpt     = rpt_q;
endmodule

// File: tb/tb_sw_cond.sv
// tb_sw_cond: directed and random checks of sw_cond against a timestamp-based event model
module tb_sw_cond;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int RPT  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] i_sw = 4'hF;
    logic [3:0] o_level, o_press, o_release, o_long, o_rpt;

    sw_cond #(.DEB_CYC(DEB), .LONG_CYC(LONG), .RPT_CYC(RPT)) dut (
        .clk(clk), .rst_n(rst_n), .i_sw(i_sw), .o_level(o_level),
        .o_press(o_press), .o_release(o_release), .o_long(o_long), .o_rpt(o_rpt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] s1, s2, lvl, e_press, e_rel, e_long, e_rpt;
    int run [4];
    int tp [4];

    task automatic model_reset();
        s1 = '0; s2 = '0; lvl = '0;
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        for (int i = 0; i < 4; i++) begin run[i] = 0; tp[i] = 0; end
    endtask

    // Level accepted after DEB mismatching samples; events placed by elapsed time since the press
    task automatic model_edge();
        int d;
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        for (int i = 0; i < 4; i++) begin
            if (s2[i] != lvl[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    run[i] = 0;
                    lvl[i] = ~lvl[i];
                    if (lvl[i]) begin e_press[i] = 1'b1; tp[i] = cyc; end
                    else e_rel[i] = 1'b1;
                end
            end else run[i] = 0;
            d = cyc - tp[i];
            e_long[i] = lvl[i] && d == LONG;
            e_rpt[i]  = lvl[i] && d >= LONG && (d - LONG) % RPT == 0;
        end
        s2 = s1;
        s1 = ~i_sw;
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert ({o_level, o_press, o_release, o_long, o_rpt} === {lvl, e_press, e_rel, e_long, e_rpt})
        else begin
            errors++;
            $error("FAIL %s cyc %0d observed lvl/pr/rel/long/rpt %h expected %h", tag, cyc,
                   {o_level, o_press, o_release, o_long, o_rpt}, {lvl, e_press, e_rel, e_long, e_rpt});
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst_n) model_edge();
            else begin model_reset(); cyc++; end
            @(negedge clk);
            check_all("model");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("reset_level", o_level, 4'b0000);
        chk("reset_pulses", o_press | o_release | o_long | o_rpt, 4'b0000);
    endtask

    initial begin
        model_reset();
        cycles(3);
        chk("reset_state", o_level | o_press | o_release | o_long | o_rpt, 4'b0000);
        rst_n = 1'b1;
        cycles(2);

        // single press latency and pulse width
        i_sw[0] = 1'b0;
        cycles(5);
        chk("press0_early", o_press, 4'b0000);
        cycles(1);
        chk("press0", o_press, 4'b0001);
        chk("level0", o_level, 4'b0001);
        cycles(1);
        chk("press0_one_cycle", o_press, 4'b0000);
        i_sw[0] = 1'b1;
        cycles(6);
        chk("release0", o_release, 4'b0001);
        cycles(6);

        // glitch shorter than debounce
        i_sw[1] = 1'b0;
        cycles(3);
        i_sw[1] = 1'b1;
        cycles(10);
        chk("glitch_level", o_level, 4'b0000);

        // long press and auto-repeat
        i_sw[2] = 1'b0;
        cycles(6);
        chk("press2", o_press, 4'b0100);
        for (int k = 1; k <= 40; k++) begin
            cycles(1);
            chk("long2", o_long, (k == 20) ? 4'b0100 : 4'b0000);
            chk("rpt2", o_rpt, (k >= 20 && k % 5 == 0) ? 4'b0100 : 4'b0000);
        end
        i_sw[2] = 1'b1;
        cycles(6);
        chk("release2", o_release, 4'b0100);
        cycles(6);

        // simultaneous presses
        i_sw = 4'b0110;
        cycles(6);
        chk("press_multi", o_press, 4'b1001);
        i_sw = 4'hF;
        cycles(8);

        // reset during a hold
        i_sw[3] = 1'b0;
        cycles(16);
        do_reset();
        cycles(1);
        rst_n = 1'b1;
        cycles(5);
        chk("press3_after_rst_early", o_press, 4'b0000);
        cycles(1);
        chk("press3_after_rst", o_press, 4'b1000);
        cycles(19);
        chk("long3_early", o_long, 4'b0000);
        cycles(1);
        chk("long3", o_long, 4'b1000);
        i_sw[3] = 1'b1;
        cycles(10);

        // release accepted at the long-press boundary
        i_sw[1] = 1'b0;
        cycles(6);
        chk("press1", o_press, 4'b0010);
        cycles(14);
        i_sw[1] = 1'b1;
        cycles(6);
        chk("release1_boundary", o_release, 4'b0010);
        chk("long1_suppressed", o_long | o_rpt, 4'b0000);
        cycles(8);

        // random bouncing with occasional resets
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 5) == 0) i_sw[i] = ~i_sw[i];
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                cycles(1);
                rst_n = 1'b1;
            end
            cycles(($urandom_range(0, 3) == 0) ? $urandom_range(5, 30) : 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
